uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/bit_sync.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: arbiter state encoding, default timeout constants and a helper
// that sizes the REQ/BUSY cycle counter from the two timeout parameters.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } arb_state_t;

    localparam int unsigned BUSY_TIMEOUT_DEFAULT  = 20000;
    localparam int unsigned FRAME_TIMEOUT_DEFAULT = 100000;

    // Counter must hold (larger timeout - 1) without wrapping; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and the UART
// transmitter.
// Signals:
//   req0_valid/req0_data/req0_ready : requester 0 (6809 data-register path)
//   req1_valid/req1_data/req1_ready : requester 1 (hardware monitor/log source)
//   tx_req/tx_data                  : start request and byte to the transmitter
//   tx_busy                         : transmitter busy, baud-clock domain
// Modports:
//   master : requesters and transmitter side
//   slave  : arbiter side
interface uart_tx_arbiter_if;
    import uart_pkg::*;

    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_req, tx_data
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_req, tx_data
    );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk   : destination clock
//   reset : asynchronous, active-high; both flops clear to 0
//   d_i   : asynchronous input level
//   q_o   : synchronized level, two clk edges of latency
module bit_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from two byte requesters.
// A grant latches the winner's byte, pulses its ready for one cycle and raises
// tx_req until the (synchronized) transmitter busy flag rises; the arbiter
// then waits for busy to fall before granting again. Both waits are bounded
// and a timeout sets a sticky error flag.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   bus         : requester/transmitter handshake bundle (slave side)
//   grant_id    : requester owning the current/last transfer
//   idle        : high in IDLE while synchronized tx_busy is low
//   err_timeout : sticky timeout flag
//   err_clear   : clears err_timeout (a simultaneous timeout wins)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT  = BUSY_TIMEOUT_DEFAULT,
    parameter int unsigned FRAME_TIMEOUT = FRAME_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus,
    output logic              grant_id,
    output logic              idle,
    output logic              err_timeout,
    input  logic              err_clear
);

    localparam int unsigned      CNT_W      = cnt_width(BUSY_TIMEOUT, FRAME_TIMEOUT);
    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

    logic             busy_s;
    arb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tx_req_q;
    logic [7:0]       tx_data_q;
    logic             rdy0_q;
    logic             rdy1_q;
    logic             gid_q;
    logic             last_q;
    logic             err_q;
    logic             any_valid;
    logic             grant_d;

    bit_sync u_busy_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.tx_busy),
        .q_o   (busy_s)
    );

    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Contention goes to the requester not served last; a lone requester always wins.
    assign grant_d   = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            gid_q     <= 1'b0;
            last_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            // Placed before the state logic so a timeout set below overrides it.
            if (err_clear) begin
                err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!busy_s && any_valid) begin
                        rdy0_q    <= ~grant_d;
                        rdy1_q    <= grant_d;
                        tx_data_q <= grant_d ? bus.req1_data : bus.req0_data;
                        gid_q     <= grant_d;
                        last_q    <= grant_d;
                        tx_req_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (busy_s) begin
                        tx_req_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_BUSY;
                    end else if (cnt_q == BUSY_LAST) begin
                        tx_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!busy_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == FRAME_LAST) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_req_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_req     = tx_req_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.req0_ready = rdy0_q;
    assign bus.req1_ready = rdy1_q;
    assign grant_id       = gid_q;
    assign err_timeout    = err_q;
    assign idle           = (state_q == ST_IDLE) && !busy_s;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with short timeouts (16 / 64).
// A reference model of the arbitration rules is compared against the DUT on
// every falling clock edge; directed scenarios add literal expectations.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int unsigned TB_BUSY_TO  = 16;
    localparam int unsigned TB_FRAME_TO = 64;

    logic clk;
    logic rst;
    logic grant_id;
    logic idle;
    logic err_timeout;
    logic err_clear;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .BUSY_TIMEOUT  (TB_BUSY_TO),
        .FRAME_TIMEOUT (TB_FRAME_TO)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .idle        (idle),
        .err_timeout (err_timeout),
        .err_clear   (err_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter stand-in: mode 0 drives busy_force, mode 1 raises busy
    // 5 cycles after tx_req is seen and holds it for 20 cycles.
    int   xmode = 0;
    logic busy_force = 1'b0;
    initial begin
        int age;
        int hold;
        age = 0;
        hold = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (xmode == 1) begin
                if (bus.tx_busy) begin
                    hold++;
                    if (hold == 20) begin
                        bus.tx_busy = 1'b0;
                        hold = 0;
                    end
                end else if (bus.tx_req) begin
                    age++;
                    if (age == 5) begin
                        bus.tx_busy = 1'b1;
                        age = 0;
                    end
                end else begin
                    age = 0;
                end
            end else begin
                bus.tx_busy = busy_force;
                age = 0;
                hold = 0;
            end
        end
    end

    // Reference model. phase: 0 waiting to grant, 1 offering byte, 2 frame in flight.
    int         m_phase;
    int         m_age;
    bit         m_s1, m_s2, m_last, m_gid, m_rdy0, m_rdy1, m_txreq, m_err;
    logic [7:0] m_data;

    task automatic model_reset();
        m_phase = 0; m_age = 0;
        m_s1 = 0; m_s2 = 0;
        m_last = 1; m_gid = 0;
        m_rdy0 = 0; m_rdy1 = 0;
        m_txreq = 0; m_err = 0;
        m_data = 8'h00;
    endtask

    initial begin
        bit bs;
        bit who;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                bs = m_s2;
                m_s2 = m_s1;
                m_s1 = bus.tx_busy;
                m_rdy0 = 0;
                m_rdy1 = 0;
                if (err_clear) m_err = 0;
                if (m_phase == 0) begin
                    if (!bs && (bus.req0_valid || bus.req1_valid)) begin
                        if (bus.req0_valid && bus.req1_valid) who = !m_last;
                        else who = bus.req1_valid;
                        m_last = who;
                        m_gid = who;
                        m_data = who ? bus.req1_data : bus.req0_data;
                        if (who) m_rdy1 = 1; else m_rdy0 = 1;
                        m_txreq = 1;
                        m_phase = 1;
                        m_age = 0;
                    end
                end else if (m_phase == 1) begin
                    m_age++;
                    if (bs) begin
                        m_txreq = 0;
                        m_phase = 2;
                        m_age = 0;
                    end else if (m_age == TB_BUSY_TO) begin
                        m_txreq = 0;
                        m_err = 1;
                        m_phase = 0;
                    end
                end else begin
                    m_age++;
                    if (!bs) begin
                        m_phase = 0;
                    end else if (m_age == TB_FRAME_TO) begin
                        m_err = 1;
                        m_phase = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_req0_ready", bus.req0_ready, m_rdy0);
            chk("m_req1_ready", bus.req1_ready, m_rdy1);
            chk("m_tx_req", bus.tx_req, m_txreq);
            chk("m_tx_data", bus.tx_data, m_data);
            chk("m_grant_id", grant_id, m_gid);
            chk("m_err_timeout", err_timeout, m_err);
            chk("m_idle", idle, (m_phase == 0) && !m_s2);
            chk("never_both_ready", bus.req0_ready & bus.req1_ready, 0);
        end
    end

    task automatic wait_grant(input int budget, output int who, output int n);
        who = -1;
        n = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n = i + 1;
            if (bus.req0_ready) begin who = 0; break; end
            if (bus.req1_ready) begin who = 1; break; end
        end
        chk("grant_seen", who >= 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (idle) break;
        end
        chk("idle_return", idle, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, n, b, r, cnt;
        int exp_id[4]   = '{0, 1, 0, 1};
        int exp_data[4] = '{8'h10, 8'h20, 8'h10, 8'h20};

        rst = 1'b1;
        err_clear = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_req", bus.tx_req, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;

        // Single byte from requester 0 through a normal frame.
        xmode = 1;
        bus.req0_data = 8'h41;
        bus.req0_valid = 1'b1;
        wait_grant(50, who, n);
        chk("t1_who", who, 0);
        chk("t1_tx_data", bus.tx_data, 8'h41);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        chk("t1_ready_one_pulse", bus.req0_ready, 0);
        b = -1; r = -1;
        for (int k = 0; k < 60; k++) begin
            if (b < 0 && bus.tx_busy) b = k;
            if (r < 0 && !bus.tx_req) r = k;
            if (b >= 0 && r >= 0) break;
            @(negedge clk);
        end
        chk("t1_txreq_drop_latency", (b >= 0) && (r - b >= 2) && (r - b <= 3), 1);
        wait_idle(60);
        chk("t1_no_err", err_timeout, 0);

        // Contention: both requesters continuously valid.
        do_reset();
        bus.req0_data = 8'h10; bus.req1_data = 8'h20;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(100, who, n);
            chk("t2_who", who, exp_id[g]);
            chk("t2_grant_id", grant_id, exp_id[g]);
            chk("t2_data", bus.tx_data, exp_data[g]);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_idle(100);

        // Transmitter never responds: REQ timeout.
        do_reset();
        xmode = 0; busy_force = 1'b0;
        bus.req0_data = 8'h5A; bus.req0_valid = 1'b1;
        wait_grant(20, who, n);
        cnt = 0;
        while (bus.tx_req && cnt < 40) begin
            cnt++;
            @(negedge clk);
            if (cnt == 1) bus.req0_valid = 1'b0;
        end
        chk("t3_txreq_cycles", cnt, 16);
        chk("t3_err_set", err_timeout, 1);
        chk("t3_idle", idle, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("t3_err_cleared", err_timeout, 0);

        // Clear held across a timeout: the set wins.
        err_clear = 1'b1;
        bus.req0_data = 8'h66; bus.req0_valid = 1'b1;
        wait_grant(20, who, n);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.tx_req) break;
            @(negedge clk);
        end
        chk("t3_set_wins", err_timeout, 1);
        err_clear = 1'b0;
        @(negedge clk);
        chk("t3_err_sticky", err_timeout, 1);

        // Busy held high blocks granting.
        do_reset();
        busy_force = 1'b1;
        repeat (3) @(negedge clk);
        bus.req1_data = 8'h77; bus.req1_valid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready || bus.tx_req || idle) cnt++;
        end
        chk("t4_blocked", cnt, 0);
        busy_force = 1'b0;
        wait_grant(20, who, n);
        chk("t4_who", who, 1);
        chk("t4_grant_delay", n, 4);
        chk("t4_data", bus.tx_data, 8'h77);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_idle(40);

        // Asynchronous reset while the byte is still being offered.
        do_reset();
        xmode = 1;
        bus.req1_valid = 1'b0;
        bus.req0_data = 8'h33; bus.req0_valid = 1'b1;
        wait_grant(20, who, n);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.tx_busy) break;
            @(negedge clk);
        end
        chk("t5_busy_seen", bus.tx_busy, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        xmode = 0; busy_force = 1'b0;
        #1;
        chk("t5_tx_req", bus.tx_req, 0);
        chk("t5_tx_data", bus.tx_data, 0);
        chk("t5_grant_id", grant_id, 0);
        chk("t5_ready", {bus.req0_ready, bus.req1_ready}, 0);
        chk("t5_err", err_timeout, 0);
        chk("t5_idle", idle, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        xmode = 1;
        bus.req0_data = 8'hA0; bus.req1_data = 8'hB1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        wait_grant(20, who, n);
        chk("t5_first_who", who, 0);
        chk("t5_first_data", bus.tx_data, 8'hA0);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_idle(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
